stall_sequencer: RTL

- Parametrised, multi-cycle successor to the pipeline's combinational opcode stall decoder.
- Classifies the decode-stage 6-bit opcode into LOAD, STORE, COP or NONE.
- Issues the class's 2-bit stop mask on the issue cycle, then holds it for a per-class programmable number of cycles using a down-counter FSM.
- Sits between decode and the pipeline-register enables.
- Supports a synchronous flush.

---
 rtl/stall_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stall_sequencer.sv
// Opcode-driven stall sequencer: issues a per-class stop mask and holds it for a programmable count.
// Optional stall-cycle performance counter enabled by defining STALL_SEQUENCER_PERF_EN.
module stall_sequencer #(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned STORE_LAT = 1,
  parameter int unsigned COP_LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             op_valid,
  input  logic             flush,
  output logic [1:0]       stop,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [15:0]      perf_stall_cycles
);

  // One extra bit so a latency of exactly 2^CNT_W is representable before the -1.
  localparam int unsigned LatW = CNT_W + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  localparam logic [OP_W-1:0] OpLoadA  = OP_W'(32);
  localparam logic [OP_W-1:0] OpLoadB  = OP_W'(33);
  localparam logic [OP_W-1:0] OpLoadC  = OP_W'(34);
  localparam logic [OP_W-1:0] OpLoadD  = OP_W'(35);
  localparam logic [OP_W-1:0] OpLoadE  = OP_W'(42);
  localparam logic [OP_W-1:0] OpStoreA = OP_W'(40);
  localparam logic [OP_W-1:0] OpStoreB = OP_W'(41);
  localparam logic [OP_W-1:0] OpCopA   = OP_W'(16);
  localparam logic [OP_W-1:0] OpCopB   = OP_W'(18);
  localparam logic [OP_W-1:0] OpCopC   = OP_W'(20);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mask_q, mask_d;

  logic [1:0]       cls_mask;
  logic [LatW-1:0]  cls_lat;
  logic [LatW-1:0]  lat_m1;
  logic             issue;

  always_comb begin
    cls_mask = 2'b00;
    cls_lat  = '0;
    case (op)
      OpLoadA, OpLoadB, OpLoadC, OpLoadD, OpLoadE: begin
        cls_mask = 2'b11;
        cls_lat  = LatW'(LOAD_LAT);
      end
      OpStoreA, OpStoreB: begin
        cls_mask = 2'b01;
        cls_lat  = LatW'(STORE_LAT);
      end
      OpCopA, OpCopB, OpCopC: begin
        cls_mask = 2'b10;
        cls_lat  = LatW'(COP_LAT);
      end
      default: ;
    endcase
  end

  assign lat_m1 = cls_lat - LatW'(1);
  assign issue  = (state_q == StIdle) && op_valid && (cls_mask != 2'b00) && (cls_lat != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    stop      = 2'b00;
    busy      = 1'b0;
    stall_cnt = '0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      mask_d  = 2'b00;
    end else if (state_q == StStall) begin
      stop      = mask_q;
      busy      = 1'b1;
      stall_cnt = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      // Guard on <=1 so a corrupted zero count still falls back to IDLE.
      if (cnt_q <= CNT_W'(1)) begin
        state_d = StIdle;
        mask_d  = 2'b00;
      end
    end else if (issue) begin
      stop    = cls_mask;
      mask_d  = cls_mask;
      cnt_d   = lat_m1[CNT_W-1:0];
      state_d = (cls_lat >= LatW'(2)) ? StStall : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mask_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

`ifdef STALL_SEQUENCER_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((stop != 2'b00) && !flush && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 16'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 16'd0;
`endif

endmodule
